// File: rtl/demux8_dispatch_if.sv
// Dispatcher bus: producer valid/ready input side plus the 8-lane output side.
// slave = dispatcher, master = producer/consumer environment.
interface demux8_dispatch_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_sel;
  logic             in_bcast;
  logic [WIDTH-1:0] out_data;
  logic [7:0]       out_valid;
  logic [7:0]       out_ready;
  logic             busy;
  logic [CNT_W-1:0] done_cnt;

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_data, out_valid, busy, done_cnt
  );

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_data, out_valid, busy, done_cnt
  );
endinterface

// File: rtl/demux8_dispatch.sv
// 1-to-8 dispatcher: holds one word on a shared bus with per-lane valids.
// Ports: clk, rst_n (async low), bus (demux8_dispatch_if.slave).
module demux8_dispatch #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  demux8_dispatch_if.slave    bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_n;
  logic [7:0]       pending;
  logic [7:0]       pending_n;
  logic [7:0]       remain;
  logic [7:0]       new_mask;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             complete;
  logic             rdy;

  // Lanes that still owe acceptance after this edge.
  assign remain   = pending & ~bus.out_ready;
  assign rdy      = (pending == 8'h00) | (remain == 8'h00);
  assign accept   = bus.in_valid & rdy;
  assign complete = (pending != 8'h00) & (remain == 8'h00);
  assign new_mask = bus.in_bcast ? 8'hFF : (8'h01 << bus.in_sel);

  // A new acceptance replaces the old mask outright; no merge.
  always_comb begin
    pending_n = remain;
    if (accept) pending_n = new_mask;
    state_n = (pending_n != 8'h00) ? HOLD : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= 8'h00;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      if (accept) data_q <= bus.in_data;
      if (complete) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = data_q;
  assign bus.out_valid = pending;
  assign bus.busy      = (state == HOLD);
  assign bus.done_cnt  = cnt_q;

endmodule

// File: tb/tb_demux8_dispatch.sv
// Directed self-checking bench for demux8_dispatch.
// Immediate assertions at each check point; one summary line at the end.
module tb_demux8_dispatch;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  demux8_dispatch_if #(.WIDTH(32), .CNT_W(16)) bus ();

  demux8_dispatch #(.WIDTH(32), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sel    = 3'd0;
    bus.in_bcast  = 1'b0;
    bus.out_ready = 8'h00;
    #12;
    chk("rst_valid", 64'(bus.out_valid), 64'h00);
    chk("rst_data", 64'(bus.out_data), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_cnt", 64'(bus.done_cnt), 64'h0);
    rst_n = 1'b1;
    step();

    // 1: reset mid-HOLD
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h1234_5678;
    bus.in_sel   = 3'd3;
    step();
    bus.in_valid = 1'b0;
    chk("t1_hold", 64'(bus.out_valid), 64'h08);
    chk("t1_busy", 64'(bus.busy), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_valid", 64'(bus.out_valid), 64'h00);
    chk("t1_rst_cnt", 64'(bus.done_cnt), 64'h0);
    chk("t1_rst_busy", 64'(bus.busy), 64'h0);
    rst_n = 1'b1;
    #1;
    chk("t1_ready", 64'(bus.in_ready), 64'h1);
    step();
    chk("t1_idle", 64'(bus.out_valid), 64'h00);

    // 2: single lane
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hDEAD_BEEF;
    bus.in_sel    = 3'd5;
    bus.out_ready = 8'h20;
    #1;
    chk("t2_ready", 64'(bus.in_ready), 64'h1);
    step();
    bus.in_valid = 1'b0;
    chk("t2_valid", 64'(bus.out_valid), 64'h20);
    chk("t2_data", 64'(bus.out_data), 64'hDEAD_BEEF);
    step();
    chk("t2_drop", 64'(bus.out_valid), 64'h00);
    chk("t2_cnt", 64'(bus.done_cnt), 64'h1);
    chk("t2_keep", 64'(bus.out_data), 64'hDEAD_BEEF);
    chk("t2_busy", 64'(bus.busy), 64'h0);

    // 3: backpressure
    bus.out_ready = 8'h00;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hCAFE_0002;
    bus.in_sel    = 3'd2;
    step();
    bus.in_data  = 32'h0BAD_0BAD;
    for (int i = 0; i < 4; i++) begin
      chk("t3_valid", 64'(bus.out_valid), 64'h04);
      chk("t3_data", 64'(bus.out_data), 64'hCAFE_0002);
      chk("t3_ready", 64'(bus.in_ready), 64'h0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 8'h04;
    #1;
    chk("t3_last_valid", 64'(bus.out_valid), 64'h04);
    chk("t3_last_data", 64'(bus.out_data), 64'hCAFE_0002);
    chk("t3_last_ready", 64'(bus.in_ready), 64'h1);
    step();
    chk("t3_done", 64'(bus.out_valid), 64'h00);
    chk("t3_cnt", 64'(bus.done_cnt), 64'h2);

    // 4: partial broadcast
    bus.out_ready = 8'h00;
    bus.in_valid  = 1'b1;
    bus.in_bcast  = 1'b1;
    bus.in_data   = 32'hB0B0_B0B0;
    bus.in_sel    = 3'd6;
    step();
    bus.in_valid = 1'b0;
    bus.in_bcast = 1'b0;
    chk("t4_ff", 64'(bus.out_valid), 64'hFF);
    bus.out_ready = 8'h0F;
    step();
    bus.out_ready = 8'h00;
    chk("t4_f0a", 64'(bus.out_valid), 64'hF0);
    step();
    chk("t4_f0b", 64'(bus.out_valid), 64'hF0);
    chk("t4_cnt_mid", 64'(bus.done_cnt), 64'h2);
    bus.out_ready = 8'hF0;
    step();
    chk("t4_zero", 64'(bus.out_valid), 64'h00);
    chk("t4_cnt", 64'(bus.done_cnt), 64'h3);
    step();
    chk("t4_cnt_once", 64'(bus.done_cnt), 64'h3);

    // 5: back-to-back
    bus.out_ready = 8'hFF;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_sel  = 3'(i);
      bus.in_data = 32'h5000_0000 + 32'(i);
      #1;
      chk("t5_ready", 64'(bus.in_ready), 64'h1);
      step();
      chk("t5_walk", 64'(bus.out_valid), 64'h1 << i);
      chk("t5_data", 64'(bus.out_data), 64'h5000_0000 + 64'(i));
    end
    bus.in_valid = 1'b0;
    step();
    chk("t5_idle", 64'(bus.out_valid), 64'h00);
    chk("t5_cnt", 64'(bus.done_cnt), 64'd11);

    // 6: counter wrap
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    chk("t6_clr", 64'(bus.done_cnt), 64'h0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      bus.in_sel = 3'(i);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    chk("t6_full", 64'(bus.done_cnt), 64'hFFFF);
    bus.in_valid = 1'b1;
    bus.in_sel   = 3'd7;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("t6_wrap", 64'(bus.done_cnt), 64'h0000);
    chk("t6_idle", 64'(bus.busy), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
